// File: rtl/display_bcd_converter.sv
// Signed 32-bit to 10-digit packed BCD converter with a one-bit-per-clock double-dabble engine.
// Optional leading-zero blanking is enabled by defining DISPLAY_BLANK_LEADING_EN.
module display_bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      rdata,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic [DIGITS-1:0]     blank,
  output logic                  busy,
  output logic                  valid
);

  localparam int SRW = 4 * DIGITS + WIDTH;
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [SRW-1:0]     sr;
  logic [SRW-1:0]     stepped;
  logic [CW-1:0]      cnt;
  logic               sign_work;
  logic               pend;
  logic [WIDTH-1:0]   pend_data;
  logic               commit;
  logic               start;
  logic [WIDTH-1:0]   start_val;
  logic [DIGITS-1:0]  blank_next;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return ~v + WIDTH'(1);
    end else begin
      return v;
    end
  endfunction

  // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [SRW-1:0] dabble_step(input logic [SRW-1:0] cur);
    logic [SRW-1:0] adj;
    adj = cur;
    for (int d = 0; d < DIGITS; d++) begin
      if (cur[WIDTH+4*d +: 4] >= 4'd5) begin
        adj[WIDTH+4*d +: 4] = cur[WIDTH+4*d +: 4] + 4'd3;
      end else begin
        adj[WIDTH+4*d +: 4] = cur[WIDTH+4*d +: 4];
      end
    end
    return {adj[SRW-2:0], 1'b0};
  endfunction

`ifdef DISPLAY_BLANK_LEADING_EN
  function automatic logic [DIGITS-1:0] lead_blank(input logic [4*DIGITS-1:0] digits);
    logic [DIGITS-1:0] mask;
    logic              seen;
    mask = '0;
    seen = 1'b0;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (digits[4*i +: 4] != 4'd0) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      mask[i] = ~seen;
    end
    mask[0] = 1'b0;
    return mask;
  endfunction
`endif

  // Next-state logic and conversion start selection; a same-cycle write beats the pending value.
  always_comb begin
    next_state = state;
    commit     = (state == CONV) && (cnt == CW'(WIDTH - 1));
    stepped    = dabble_step(sr);
    start      = 1'b0;
    start_val  = wdata;
    case (state)
      IDLE: begin
        if (we) begin
          next_state = CONV;
          start      = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      CONV: begin
        if (commit && (we || pend)) begin
          next_state = CONV;
          start      = 1'b1;
          start_val  = we ? wdata : pend_data;
        end else if (commit) begin
          next_state = IDLE;
        end else begin
          next_state = CONV;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
`ifdef DISPLAY_BLANK_LEADING_EN
    blank_next = lead_blank(stepped[SRW-1:WIDTH]);
`else
    blank_next = '0;
`endif
  end

  // State, conversion datapath and committed outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      sign_work <= 1'b0;
      pend      <= 1'b0;
      pend_data <= '0;
      rdata     <= '0;
      bcd       <= '0;
      neg       <= 1'b0;
      blank     <= '0;
      busy      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state == CONV);
      valid <= commit;
      if (we) begin
        rdata <= wdata;
      end
      if (start) begin
        sr        <= {{(4*DIGITS){1'b0}}, magnitude(start_val)};
        sign_work <= start_val[WIDTH-1];
        cnt       <= '0;
        pend      <= 1'b0;
      end else if (state == CONV) begin
        sr  <= stepped;
        cnt <= cnt + CW'(1);
        if (we) begin
          pend_data <= wdata;
          pend      <= 1'b1;
        end
      end
      // Outputs move only on the commit edge so downstream never sees partial digits.
      if (commit) begin
        bcd   <= stepped[SRW-1:WIDTH];
        neg   <= sign_work;
        blank <= blank_next;
      end
    end
  end

endmodule
